// File: rtl/mpu_bias_calib.sv
// MPU6050 still-board bias calibration. The biases and calib_done_out appear one cycle after the last accumulated sample.
// `define STILLNESS_CHECK_EN to restart accumulation when the gyro moves away from its first sample.
module mpu_bias_calib #(
   parameter int LOG2_N        = 8,
   parameter int DISCARD_CNT   = 16,
   parameter int ACC_Z_1G      = 16384,
   parameter int GYRO_STILL_TH = 200
) (
   input  logic               clk_in,
   input  logic               rst_n,
   input  logic               recalib_in,
   input  logic               sample_vld_in,
   input  logic signed [15:0] acc_x_in,
   input  logic signed [15:0] acc_y_in,
   input  logic signed [15:0] acc_z_in,
   input  logic signed [15:0] temp_in,
   input  logic signed [15:0] gyro_x_in,
   input  logic signed [15:0] gyro_y_in,
   input  logic signed [15:0] gyro_z_in,
   output logic signed [15:0] acc_x_bias_out,
   output logic signed [15:0] acc_y_bias_out,
   output logic signed [15:0] acc_z_bias_out,
   output logic signed [15:0] temp_bias_out,
   output logic signed [15:0] gyro_x_bias_out,
   output logic signed [15:0] gyro_y_bias_out,
   output logic signed [15:0] gyro_z_bias_out,
   output logic               calib_done_out,
   output logic               calib_busy_out
);

   localparam int AW = 16 + LOG2_N;
   localparam logic [1:0] S_DISCARD = 2'd0;
   localparam logic [1:0] S_ACCUM   = 2'd1;
   localparam logic [1:0] S_FINAL   = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [1:0]        r_state;
   logic [7:0]        r_disc_cnt;
   logic [LOG2_N-1:0] r_acc_cnt;
   logic              r_done;
   logic              r_busy;
   logic signed [AW-1:0] r_acc  [7];
   logic signed [15:0]   r_bias [7];
   logic signed [15:0]   w_in   [7];
   logic signed [15:0]   w_avg  [7];
   logic                 w_abort;

   assign w_in[0] = acc_x_in;
   assign w_in[1] = acc_y_in;
   assign w_in[2] = acc_z_in;
   assign w_in[3] = temp_in;
   assign w_in[4] = gyro_x_in;
   assign w_in[5] = gyro_y_in;
   assign w_in[6] = gyro_z_in;

   // Arithmetic shift floors toward -inf; the average always fits in 16 bits.
   always_comb begin
      for (int k = 0; k < 7; k++) begin
         w_avg[k] = 16'(r_acc[k] >>> LOG2_N);
      end
   end

`ifdef STILLNESS_CHECK_EN
   logic signed [15:0] r_ref [3];
   logic               r_have_ref;
   logic signed [16:0] w_dev [3];
   logic               w_moved;

   always_comb begin
      w_moved = 1'b0;
      for (int j = 0; j < 3; j++) begin
         w_dev[j] = 17'(w_in[4+j]) - 17'(r_ref[j]);
         if (w_dev[j] > GYRO_STILL_TH || w_dev[j] < -GYRO_STILL_TH) w_moved = 1'b1;
      end
   end

   assign w_abort = r_have_ref && w_moved;

   // After an abort the next accepted sample becomes the new reference.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_have_ref <= 1'b0;
         for (int j = 0; j < 3; j++) r_ref[j] <= '0;
      end else if (recalib_in) begin
         r_have_ref <= 1'b0;
      end else if (r_state == S_ACCUM && sample_vld_in) begin
         if (w_abort) begin
            r_have_ref <= 1'b0;
         end else if (!r_have_ref) begin
            r_have_ref <= 1'b1;
            for (int j = 0; j < 3; j++) r_ref[j] <= w_in[4+j];
         end
      end
   end
`else
   assign w_abort = 1'b0;
`endif

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_DISCARD;
         r_disc_cnt <= '0;
         r_acc_cnt  <= '0;
         r_done     <= 1'b0;
         r_busy     <= 1'b1;
         for (int k = 0; k < 7; k++) begin
            r_acc[k]  <= '0;
            r_bias[k] <= '0;
         end
      end else if (recalib_in) begin
         r_state    <= S_DISCARD;
         r_disc_cnt <= '0;
         r_acc_cnt  <= '0;
         r_done     <= 1'b0;
         r_busy     <= 1'b1;
         for (int k = 0; k < 7; k++) r_acc[k] <= '0;
      end else begin
         case (r_state)
            S_DISCARD: begin
               if (DISCARD_CNT == 0) begin
                  r_state <= S_ACCUM;
                  for (int k = 0; k < 7; k++) r_acc[k] <= '0;
               end else if (sample_vld_in) begin
                  r_disc_cnt <= r_disc_cnt + 8'd1;
                  if (r_disc_cnt == 8'(DISCARD_CNT - 1)) begin
                     r_state <= S_ACCUM;
                     for (int k = 0; k < 7; k++) r_acc[k] <= '0;
                  end
               end
            end
            S_ACCUM: begin
               if (sample_vld_in) begin
                  if (w_abort) begin
                     r_acc_cnt <= '0;
                     for (int k = 0; k < 7; k++) r_acc[k] <= '0;
                  end else begin
                     r_acc_cnt <= r_acc_cnt + 1'b1;
                     for (int k = 0; k < 7; k++) r_acc[k] <= r_acc[k] + AW'(w_in[k]);
                     if (r_acc_cnt == '1) r_state <= S_FINAL;
                  end
               end
            end
            S_FINAL: begin
               for (int k = 0; k < 7; k++) r_bias[k] <= w_avg[k];
               // Remove 1 g from Z; the 16-bit result wraps for extreme averages.
               r_bias[2] <= 16'(17'(w_avg[2]) - 17'(ACC_Z_1G));
               r_done    <= 1'b1;
               r_busy    <= 1'b0;
               r_state   <= S_DONE;
            end
            default: ;
         endcase
      end
   end

   assign acc_x_bias_out  = r_bias[0];
   assign acc_y_bias_out  = r_bias[1];
   assign acc_z_bias_out  = r_bias[2];
   assign temp_bias_out   = r_bias[3];
   assign gyro_x_bias_out = r_bias[4];
   assign gyro_y_bias_out = r_bias[5];
   assign gyro_z_bias_out = r_bias[6];
   assign calib_done_out  = r_done;
   assign calib_busy_out  = r_busy;

endmodule
